// File: rtl/axi_write_slave.sv
// AXI3 write-channel responder: takes one AW/W burst at a time, stores it byte-lane-wise
// in a word memory, and answers on B. A combinational debug port reads the memory back.
module axi_write_slave #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [WIDTH/8-1:0]       awid,
    input  logic [WIDTH-1:0]         awaddr,
    input  logic [WIDTH/8-1:0]       awlen,
    input  logic [SIZE-1:0]          awsize,
    input  logic [SIZE-2:0]          awburst,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [WIDTH/8-1:0]       wid,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [WIDTH/8-1:0]       wstrb,
    input  logic                     wlast,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [WIDTH/8-1:0]       bid,
    output logic [SIZE-2:0]          bresp,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);
    localparam int IW    = WIDTH / 8;
    localparam int BW    = SIZE - 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = WIDTH / 8;
    localparam int OFFB  = $clog2(WIDTH / 8);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(DEPTH * WIDTH / 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [BW-1:0] B_FIXED = BW'(0);
    localparam logic [BW-1:0] B_WRAP  = BW'(2);
    localparam logic [BW-1:0] B_RSVD  = {BW{1'b1}};
    localparam logic [BW-1:0] R_OKAY  = BW'(0);
    localparam logic [BW-1:0] R_SLV   = BW'(2);
    localparam logic [BW-1:0] R_DEC   = BW'(3);

    logic [1:0]       state_reg;
    logic [IW-1:0]    id_reg;
    logic [IW-1:0]    len_reg;
    logic [IW-1:0]    bid_reg;
    logic [WIDTH-1:0] addr_reg;
    logic [SIZE-1:0]  size_reg;
    logic [BW-1:0]    burst_reg;
    logic [BW-1:0]    bresp_reg;
    logic [IW:0]      beat_reg;
    logic             decerr_reg;
    logic             inhibit_reg;
    logic             slverr_reg;

    logic             aw_hs;
    logic             w_hs;
    logic [WIDTH-1:0] bytes;
    logic [WIDTH-1:0] wrap_mask;
    logic [WIDTH-1:0] addr_inc;
    logic [WIDTH-1:0] addr_next;
    logic [WIDTH-1:0] aw_align_mask;
    logic             aw_wrap_len_ok;
    logic             aw_slverr;
    logic             aw_decerr;
    logic             beat_decerr;
    logic             id_mismatch;
    logic             extra_beat;
    logic             early_last;
    logic             beat_inhibit;
    logic             slv_final;
    logic             do_write;
    logic [BW-1:0]    resp_final;
    logic [AW-1:0]    widx;

    assign awready = (state_reg == S_IDLE) & reset;
    assign wready  = (state_reg == S_DATA);
    assign bvalid  = (state_reg == S_RESP);
    assign bid     = bid_reg;
    assign bresp   = bresp_reg;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    assign bytes     = WIDTH'(1) << size_reg;
    assign wrap_mask = ((WIDTH'(len_reg) + WIDTH'(1)) << size_reg) - WIDTH'(1);
    assign addr_inc  = addr_reg + bytes;

    always_comb begin
        addr_next = addr_inc;
        if (burst_reg == B_FIXED)
            addr_next = addr_reg;
        else if (burst_reg == B_WRAP)
            addr_next = (addr_reg & ~wrap_mask) | (addr_inc & wrap_mask);
    end

    // Burst-shape errors are known at AW time and inhibit every beat of the burst.
    assign aw_align_mask  = (WIDTH'(1) << awsize) - WIDTH'(1);
    assign aw_wrap_len_ok = (awlen == IW'(1)) | (awlen == IW'(3)) |
                            (awlen == IW'(7)) | (awlen == IW'(15));
    assign aw_slverr = (awburst == B_RSVD) | (awsize > SIZE'(OFFB)) |
                       ((awburst == B_WRAP) & (!aw_wrap_len_ok | ((awaddr & aw_align_mask) != '0)));
    assign aw_decerr = (awaddr >= LIMIT);

    assign beat_decerr  = decerr_reg | (addr_reg >= LIMIT);
    assign id_mismatch  = (wid != id_reg);
    assign extra_beat   = (beat_reg > {1'b0, len_reg});
    assign early_last   = wlast & (beat_reg < {1'b0, len_reg});
    assign beat_inhibit = inhibit_reg | id_mismatch;
    assign slv_final    = beat_inhibit | slverr_reg | extra_beat | early_last;
    assign resp_final   = beat_decerr ? R_DEC : (slv_final ? R_SLV : R_OKAY);
    assign do_write     = reset & w_hs & !beat_decerr & !beat_inhibit & !extra_beat;
    assign widx         = addr_reg[OFFB +: AW];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            bid_reg     <= '0;
            bresp_reg   <= '0;
            beat_reg    <= '0;
            decerr_reg  <= 1'b0;
            inhibit_reg <= 1'b0;
            slverr_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (aw_hs) begin
                        id_reg      <= awid;
                        addr_reg    <= awaddr;
                        len_reg     <= awlen;
                        size_reg    <= awsize;
                        burst_reg   <= awburst;
                        beat_reg    <= '0;
                        decerr_reg  <= aw_decerr;
                        inhibit_reg <= aw_slverr;
                        slverr_reg  <= 1'b0;
                        state_reg   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        // Saturate so an overlong burst never wraps back into range.
                        if (beat_reg != '1)
                            beat_reg <= beat_reg + 1'b1;
                        addr_reg    <= addr_next;
                        decerr_reg  <= beat_decerr;
                        inhibit_reg <= beat_inhibit;
                        slverr_reg  <= slverr_reg | extra_beat;
                        if (wlast) begin
                            bid_reg   <= id_reg;
                            bresp_reg <= resp_final;
                            state_reg <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bready)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (do_write && wstrb[gi])
                    lane_mem[widx] <= wdata[gi*8 +: 8];
            end

            assign dbg_data[gi*8 +: 8] = lane_mem[dbg_addr];
        end
    endgenerate

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: inputs driven on the falling edge, outputs sampled there
// too, one task per scenario with inline comparisons against hand-computed values.
module tb_axi_write_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    always #5 clk = ~clk;

    axi_write_slave #(.WIDTH(32), .SIZE(3), .DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Drivers: called on a falling edge, return on the falling edge after the handshake.
    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        n_checks++;
        if (awready !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_handshake awready=%b required 1 (timeout)", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                          input logic [3:0] id, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wid = id; wlast = last; wvalid = 1'b1;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        n_checks++;
        if (wready !== 1'b1) begin
            n_fail++;
            $display("FAIL w_handshake wready=%b required 1 (timeout)", wready);
        end
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b(output logic [3:0] id, output logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL b_handshake bvalid=%b required 1 (timeout)", bvalid);
        end
        id = bid; resp = bresp;
        $display("B transaction: bid=%0h bresp=%b", id, resp);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic read_mem(input logic [7:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic test_reset;
        reset = 1'b0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        awid = 4'h0; awaddr = 32'h0; awlen = 4'h0; awsize = 3'd2; awburst = INCR;
        wid = 4'h0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; dbg_addr = 8'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 4'h0 || bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs awready=%b wready=%b bvalid=%b bid=%h bresp=%b required all 0",
                     awready, wready, bvalid, bid, bresp);
        end
        awvalid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release awready=%b wready=%b required 1 0", awready, wready);
        end
        @(negedge clk);
        wvalid = 1'b0;
        $display("reset transaction done");
    endtask

    task automatic test_incr;
        logic [3:0] rid; logic [1:0] rr; logic [31:0] d;
        send_aw(4'h3, 32'h10, 4'd3, 3'd2, INCR);
        n_checks++;
        if (wready !== 1'b1) begin
            n_fail++; $display("FAIL incr_wready wready=%b required 1", wready);
        end
        for (int i = 0; i < 4; i++) send_w(32'hA0 + i, 4'hF, 4'h3, i == 3);
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++; $display("FAIL incr_bvalid_latency bvalid=%b required 1", bvalid);
        end
        wait_b(rid, rr);
        n_checks++;
        if (rid !== 4'h3 || rr !== 2'b00) begin
            n_fail++; $display("FAIL incr_resp bid=%h bresp=%b required 3 00", rid, rr);
        end
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++; $display("FAIL incr_bvalid_drop bvalid=%b required 0", bvalid);
        end
        for (int i = 0; i < 4; i++) begin
            read_mem(8'(4 + i), d);
            n_checks++;
            if (d !== 32'hA0 + i) begin
                n_fail++; $display("FAIL incr_mem word=%0d got=%h required=%h", 4 + i, d, 32'hA0 + i);
            end
        end
    endtask

    task automatic test_wrap;
        logic [3:0] rid; logic [1:0] rr; logic [31:0] d;
        logic [7:0] words [4] = '{8'h0E, 8'h0F, 8'h0C, 8'h0D};
        send_aw(4'h1, 32'h38, 4'd3, 3'd2, WRAP);
        for (int i = 0; i < 4; i++) send_w(32'hB0 + i, 4'hF, 4'h1, i == 3);
        wait_b(rid, rr);
        n_checks++;
        if (rid !== 4'h1 || rr !== 2'b00) begin
            n_fail++; $display("FAIL wrap_resp bid=%h bresp=%b required 1 00", rid, rr);
        end
        for (int i = 0; i < 4; i++) begin
            read_mem(words[i], d);
            n_checks++;
            if (d !== 32'hB0 + i) begin
                n_fail++; $display("FAIL wrap_mem word=%h got=%h required=%h", words[i], d, 32'hB0 + i);
            end
        end
    endtask

    task automatic test_fixed;
        logic [3:0] rid; logic [1:0] rr; logic [31:0] d;
        send_aw(4'h2, 32'h20, 4'd1, 3'd2, INCR);
        send_w(32'hDEADBEEF, 4'hF, 4'h2, 1'b0);
        send_w(32'h12345678, 4'hF, 4'h2, 1'b1);
        wait_b(rid, rr);
        send_aw(4'h2, 32'h20, 4'd2, 3'd2, FIXED);
        send_w(32'h00000011, 4'h1, 4'h2, 1'b0);
        send_w(32'h00002200, 4'h2, 4'h2, 1'b0);
        send_w(32'h00330000, 4'h4, 4'h2, 1'b1);
        wait_b(rid, rr);
        n_checks++;
        if (rid !== 4'h2 || rr !== 2'b00) begin
            n_fail++; $display("FAIL fixed_resp bid=%h bresp=%b required 2 00", rid, rr);
        end
        read_mem(8'd8, d);
        n_checks++;
        if (d !== 32'hDE332211) begin
            n_fail++; $display("FAIL fixed_word8 got=%h required=DE332211", d);
        end
        read_mem(8'd9, d);
        n_checks++;
        if (d !== 32'h12345678) begin
            n_fail++; $display("FAIL fixed_word9 got=%h required=12345678", d);
        end
    endtask

    task automatic test_errors;
        logic [3:0] rid; logic [1:0] rr; logic [31:0] d;
        // Start address out of range.
        send_aw(4'h4, 32'h410, 4'd1, 3'd2, INCR);
        send_w(32'h11111111, 4'hF, 4'h4, 1'b0);
        send_w(32'h11111111, 4'hF, 4'h4, 1'b1);
        wait_b(rid, rr);
        n_checks++;
        if (rid !== 4'h4 || rr !== 2'b11) begin
            n_fail++; $display("FAIL decerr_start bid=%h bresp=%b required 4 11", rid, rr);
        end
        read_mem(8'd4, d);
        n_checks++;
        if (d !== 32'hA0) begin
            n_fail++; $display("FAIL decerr_start_mem got=%h required=000000A0", d);
        end
        // Burst runs off the top of memory on its second beat.
        send_aw(4'h4, 32'h3FC, 4'd1, 3'd2, INCR);
        send_w(32'h0FF00FF0, 4'hF, 4'h4, 1'b0);
        send_w(32'h22222222, 4'hF, 4'h4, 1'b1);
        wait_b(rid, rr);
        read_mem(8'd255, d);
        n_checks++;
        if (rr !== 2'b11 || d !== 32'h0FF00FF0) begin
            n_fail++; $display("FAIL decerr_cross bresp=%b word255=%h required 11 0FF00FF0", rr, d);
        end
        // Reserved burst type.
        send_aw(4'h3, 32'h10, 4'd0, 3'd2, RSVD);
        send_w(32'h00000BAD, 4'hF, 4'h3, 1'b1);
        wait_b(rid, rr);
        read_mem(8'd4, d);
        n_checks++;
        if (rr !== 2'b10 || d !== 32'hA0) begin
            n_fail++; $display("FAIL slverr_rsvd bresp=%b word4=%h required 10 000000A0", rr, d);
        end
        // WID differs from AWID.
        send_aw(4'h3, 32'h14, 4'd1, 3'd2, INCR);
        send_w(32'h55555555, 4'hF, 4'h5, 1'b0);
        send_w(32'h66666666, 4'hF, 4'h5, 1'b1);
        wait_b(rid, rr);
        read_mem(8'd5, d);
        n_checks++;
        if (rid !== 4'h3 || rr !== 2'b10 || d !== 32'hA1) begin
            n_fail++; $display("FAIL slverr_wid bid=%h bresp=%b word5=%h required 3 10 000000A1", rid, rr, d);
        end
        read_mem(8'd6, d);
        n_checks++;
        if (d !== 32'hA2) begin
            n_fail++; $display("FAIL slverr_wid_word6 got=%h required=000000A2", d);
        end
        // WRAP with an illegal length.
        send_aw(4'h3, 32'h30, 4'd2, 3'd2, WRAP);
        for (int i = 0; i < 3; i++) send_w(32'h77777777, 4'hF, 4'h3, i == 2);
        wait_b(rid, rr);
        read_mem(8'h0C, d);
        n_checks++;
        if (rr !== 2'b10 || d !== 32'hB2) begin
            n_fail++; $display("FAIL slverr_wrap_len bresp=%b word12=%h required 10 000000B2", rr, d);
        end
        // WRAP start not aligned to the beat size.
        send_aw(4'h3, 32'h3A, 4'd1, 3'd2, WRAP);
        send_w(32'h88888888, 4'hF, 4'h3, 1'b0);
        send_w(32'h88888888, 4'hF, 4'h3, 1'b1);
        wait_b(rid, rr);
        read_mem(8'h0E, d);
        n_checks++;
        if (rr !== 2'b10 || d !== 32'hB0) begin
            n_fail++; $display("FAIL slverr_wrap_align bresp=%b word14=%h required 10 000000B0", rr, d);
        end
        // Beat size wider than the bus.
        send_aw(4'h3, 32'h18, 4'd0, 3'd3, INCR);
        send_w(32'h99999999, 4'hF, 4'h3, 1'b1);
        wait_b(rid, rr);
        read_mem(8'd6, d);
        n_checks++;
        if (rr !== 2'b10 || d !== 32'hA2) begin
            n_fail++; $display("FAIL slverr_size bresp=%b word6=%h required 10 000000A2", rr, d);
        end
    endtask

    task automatic test_wlast;
        logic [3:0] rid; logic [1:0] rr; logic [31:0] d;
        send_aw(4'h6, 32'h40, 4'd3, 3'd2, INCR);
        send_w(32'hC0, 4'hF, 4'h6, 1'b0);
        send_w(32'hC1, 4'hF, 4'h6, 1'b1);
        n_checks++;
        if (bvalid !== 1'b1 || wready !== 1'b0) begin
            n_fail++; $display("FAIL early_last_end bvalid=%b wready=%b required 1 0", bvalid, wready);
        end
        wait_b(rid, rr);
        n_checks++;
        if (rid !== 4'h6 || rr !== 2'b10) begin
            n_fail++; $display("FAIL early_last_resp bid=%h bresp=%b required 6 10", rid, rr);
        end
        for (int i = 0; i < 2; i++) begin
            read_mem(8'(16 + i), d);
            n_checks++;
            if (d !== 32'hC0 + i) begin
                n_fail++; $display("FAIL early_last_mem word=%0d got=%h required=%h", 16 + i, d, 32'hC0 + i);
            end
        end
        // Missing WLAST: third beat of a two-beat burst is accepted but dropped.
        send_aw(4'h6, 32'h10, 4'd1, 3'd2, INCR);
        send_w(32'hD0, 4'hF, 4'h6, 1'b0);
        send_w(32'hD1, 4'hF, 4'h6, 1'b0);
        send_w(32'hD2, 4'hF, 4'h6, 1'b1);
        wait_b(rid, rr);
        n_checks++;
        if (rr !== 2'b10) begin
            n_fail++; $display("FAIL missing_last_resp bresp=%b required 10", rr);
        end
        read_mem(8'd5, d);
        n_checks++;
        if (d !== 32'hD1) begin
            n_fail++; $display("FAIL missing_last_word5 got=%h required=000000D1", d);
        end
        read_mem(8'd6, d);
        n_checks++;
        if (d !== 32'hA2) begin
            n_fail++; $display("FAIL missing_last_word6 got=%h required=000000A2", d);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] rid; logic [1:0] rr; logic [31:0] d;
        send_aw(4'h7, 32'h50, 4'd0, 3'd2, INCR);
        send_w(32'hE0, 4'hF, 4'h7, 1'b1);
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bvalid !== 1'b1 || bid !== 4'h7 || bresp !== 2'b00 || awready !== 1'b0) begin
                n_fail++;
                $display("FAIL b_stall cycle=%0d bvalid=%b bid=%h bresp=%b awready=%b required 1 7 00 0",
                         i, bvalid, bid, bresp, awready);
            end
            @(negedge clk);
        end
        awvalid = 1'b0;
        wait_b(rid, rr);
        n_checks++;
        if (rid !== 4'h7 || rr !== 2'b00 || awready !== 1'b1) begin
            n_fail++; $display("FAIL b_stall_resp bid=%h bresp=%b awready=%b required 7 00 1", rid, rr, awready);
        end
        send_aw(4'h8, 32'h54, 4'd0, 3'd2, INCR);
        send_w(32'hE1, 4'hF, 4'h8, 1'b1);
        wait_b(rid, rr);
        read_mem(8'd20, d);
        n_checks++;
        if (d !== 32'hE0) begin
            n_fail++; $display("FAIL b2b_word20 got=%h required=000000E0", d);
        end
        read_mem(8'd21, d);
        n_checks++;
        if (rid !== 4'h8 || rr !== 2'b00 || d !== 32'hE1) begin
            n_fail++; $display("FAIL b2b_second bid=%h bresp=%b word21=%h required 8 00 000000E1", rid, rr, d);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] rid; logic [1:0] rr; logic [31:0] d;
        send_aw(4'h9, 32'h80, 4'd3, 3'd2, INCR);
        send_w(32'h00005555, 4'hF, 4'h9, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 4'h0 || bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_outputs awready=%b wready=%b bvalid=%b bid=%h bresp=%b required all 0",
                     awready, wready, bvalid, bid, bresp);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (awready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_awready awready=%b required 1", awready);
        end
        read_mem(8'd32, d);
        n_checks++;
        if (d !== 32'h00005555) begin
            n_fail++; $display("FAIL reset_mid_retained got=%h required=00005555", d);
        end
        @(negedge clk);
        send_aw(4'h1, 32'h84, 4'd0, 3'd2, INCR);
        send_w(32'h00006666, 4'hF, 4'h1, 1'b1);
        wait_b(rid, rr);
        read_mem(8'd33, d);
        n_checks++;
        if (rid !== 4'h1 || rr !== 2'b00 || d !== 32'h00006666) begin
            n_fail++; $display("FAIL reset_mid_after bid=%h bresp=%b word33=%h required 1 00 00006666", rid, rr, d);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_errors();
        test_wlast();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
